// File: rtl/denorm_pkg.sv
// Shared types and constants for the vector de-normalization datapath.
package denorm_pkg;

  typedef enum logic [1:0] {IDLE, MUL, DONE} denorm_state_e;

  localparam int DATAWIDTH_DEF = 16;
  localparam int MUL_CYCLES    = DATAWIDTH_DEF + 1;
  localparam int NUM_LANES     = 4;

  typedef logic [1:0] lane_idx_t;

  // One multiplier bit per cycle; operands are DATAWIDTH+1 bits wide.
  function automatic int mul_cycles(input int dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/seq_shift_add_mul.sv
// Iterative shift-add multiplier, LSB first, one multiplier bit per cycle.
// The start cycle already consumes bit 0, so a W-bit multiply takes exactly
// W cycles; 'product' is the accumulator value after the current step, which
// on the done cycle is the full product.
module seq_shift_add_mul #(
  parameter int W = 17
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = $clog2(W);

  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [2*W-1:0] cur_mcand;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic           load;
  logic           cur_bit;

  assign load = start && !busy;
  assign done = busy && (cnt == CW'(W - 1));

  // Current step: on load use the fresh operands, otherwise the shifted ones.
  always_comb begin
    cur_mcand = load ? {{W{1'b0}}, a} : mcand;
    cur_bit   = load ? b[0] : mplier[0];
    product   = (load ? '0 : acc) + (cur_bit ? cur_mcand : '0);
  end

  // Accumulate one partial product per cycle; clear everything after the last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (load) begin
      acc    <= product;
      mcand  <= cur_mcand << 1;
      mplier <= b >> 1;
      cnt    <= CW'(1);
      busy   <= 1'b1;
    end else if (busy) begin
      if (done) begin
        acc    <= '0;
        mcand  <= '0;
        mplier <= '0;
        cnt    <= '0;
        busy   <= 1'b0;
      end else begin
        acc    <= product;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vec_denorm_seq.sv
// Rebuilds components A..D from unit components and magnitude: X = q_X * mag,
// lanes processed A..D through one shared sequential multiplier.
// Optional build macro DENORM_ROUND_EN: round half up before the fractional
// shift instead of truncating. Latency is the same either way.
module vec_denorm_seq
  import denorm_pkg::*;
#(
  parameter int DATAWIDTH   = 16,
  parameter int FRAC_BITS   = 8,
  parameter int INSTANCE_ID = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [DATAWIDTH:0]   q_A,
  input  logic [DATAWIDTH:0]   q_B,
  input  logic [DATAWIDTH:0]   q_C,
  input  logic [DATAWIDTH:0]   q_D,
  input  logic [DATAWIDTH:0]   mag,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [DATAWIDTH-1:0] out_A,
  output logic [DATAWIDTH-1:0] out_B,
  output logic [DATAWIDTH-1:0] out_C,
  output logic [DATAWIDTH-1:0] out_D,
  output logic [3:0]           o_sat
);

  localparam int QW   = DATAWIDTH + 1;
  localparam int PW   = 2 * QW;
  localparam int MCYC = mul_cycles(DATAWIDTH);
  localparam int BW   = $clog2(MCYC);

`ifdef DENORM_ROUND_EN
  localparam logic [PW-1:0] ROUND_ADD = PW'(1) << (FRAC_BITS - 1);
`else
  localparam logic [PW-1:0] ROUND_ADD = '0;
`endif

  // The instance tag is trace metadata only; negative tags are not meaningful.
  if (INSTANCE_ID < 0) begin : g_neg_instance_id_unsupported
  end

  denorm_state_e state, state_nxt;
  lane_idx_t     lane;
  logic [BW-1:0] bit_cnt;

  logic [NUM_LANES-1:0][QW-1:0]        q_r;
  logic [QW-1:0]                       mag_r;
  logic [NUM_LANES-1:0][DATAWIDTH-1:0] res;
  logic [NUM_LANES-1:0]                sat;

  logic           accept;
  logic           mul_start;
  logic           mul_busy;
  logic           mul_done;
  logic           lane_end;
  logic [PW-1:0]  product;
  logic [PW-1:0]  rounded;
  logic [PW-1:0]  shifted;
  logic           lane_sat;
  logic [DATAWIDTH-1:0] lane_res;

  assign accept    = i_valid && i_ready;
  // Kick the multiplier whenever it is idle in MUL: once per lane.
  assign mul_start = (state == MUL) && !mul_busy;
  assign lane_end  = mul_done && (bit_cnt == BW'(MCYC - 1));

  seq_shift_add_mul #(.W(QW)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (q_r[lane]),
    .b       (mag_r),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake outputs; no overlap between vectors.
  always_comb begin
    state_nxt = state;
    i_ready   = 1'b0;
    o_valid   = 1'b0;
    case (state)
      IDLE: begin
        i_ready = 1'b1;
        if (i_valid) state_nxt = MUL;
      end
      MUL: begin
        if (lane_end && (lane == lane_idx_t'(NUM_LANES - 1))) state_nxt = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        if (o_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Round (optional), drop fraction bits, clamp to the output width.
  always_comb begin
    rounded  = product + ROUND_ADD;
    shifted  = rounded >> FRAC_BITS;
    lane_sat = |shifted[PW-1:DATAWIDTH];
    lane_res = lane_sat ? '1 : shifted[DATAWIDTH-1:0];
  end

  // Operand capture, lane/bit sequencing and per-lane result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r     <= '0;
      mag_r   <= '0;
      lane    <= '0;
      bit_cnt <= '0;
      res     <= '0;
      sat     <= '0;
    end else if (accept) begin
      q_r     <= {q_D, q_C, q_B, q_A};
      mag_r   <= mag;
      lane    <= '0;
      bit_cnt <= '0;
    end else if (state == MUL) begin
      if (lane_end) begin
        res[lane] <= lane_res;
        sat[lane] <= lane_sat;
        lane      <= lane + 1'b1;
        bit_cnt   <= '0;
      end else begin
        bit_cnt   <= bit_cnt + 1'b1;
      end
    end
  end

  assign out_A = res[0];
  assign out_B = res[1];
  assign out_C = res[2];
  assign out_D = res[3];
  assign o_sat = sat;

endmodule

// File: tb/tb_vec_denorm_seq.sv
// Randomized + directed bench for vec_denorm_seq against an arithmetic model.
module tb_vec_denorm_seq;

  localparam int DW  = 16;
  localparam int FB  = 8;
  localparam int LAT = 4 * (DW + 1);
`ifdef DENORM_ROUND_EN
  localparam longint unsigned RND = 128;
`else
  localparam longint unsigned RND = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          o_ready = 1'b1;
  logic [DW:0]   q_A = '0, q_B = '0, q_C = '0, q_D = '0, mag = '0;
  logic          i_ready, o_valid;
  logic [DW-1:0] out_A, out_B, out_C, out_D;
  logic [3:0]    o_sat;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  vec_denorm_seq #(.DATAWIDTH(DW), .FRAC_BITS(FB), .INSTANCE_ID(0)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
    .q_A(q_A), .q_B(q_B), .q_C(q_C), .q_D(q_D), .mag(mag),
    .o_valid(o_valid), .o_ready(o_ready),
    .out_A(out_A), .out_B(out_B), .out_C(out_C), .out_D(out_D), .o_sat(o_sat)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: {sat, value} for one lane from plain integer arithmetic.
  function automatic logic [DW:0] ref_lane(input logic [DW:0] q, input logic [DW:0] m);
    longint unsigned r;
    r = ((longint'(q) * longint'(m)) + RND) >> FB;
    if (r >= 65536) return {1'b1, 16'hFFFF};
    return {1'b0, r[15:0]};
  endfunction

  // Present a vector, wait (bounded) for i_ready, return just after the accept edge.
  task automatic accept_vec(input logic [DW:0] a, b, c, d, m);
    int w;
    w = 0;
    @(negedge clk);
    q_A = a; q_B = b; q_C = c; q_D = d; mag = m; i_valid = 1'b1;
    while (!i_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("accept_wait", 64'(w < 100), 64'(1));
    @(posedge clk);
    #1 i_valid = 1'b0;
  endtask

  // Wait (bounded) for o_valid, then check latency and every lane.
  task automatic collect(input string tag, input logic [DW:0] a, b, c, d, m);
    int lat;
    logic [DW:0] e0, e1, e2, e3;
    e0 = ref_lane(a, m); e1 = ref_lane(b, m); e2 = ref_lane(c, m); e3 = ref_lane(d, m);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!o_valid && lat < 200);
    chk({tag, "_lat"}, 64'(lat), 64'(LAT));
    chk({tag, "_A"}, 64'(out_A), 64'(e0[DW-1:0]));
    chk({tag, "_B"}, 64'(out_B), 64'(e1[DW-1:0]));
    chk({tag, "_C"}, 64'(out_C), 64'(e2[DW-1:0]));
    chk({tag, "_D"}, 64'(out_D), 64'(e3[DW-1:0]));
    chk({tag, "_sat"}, 64'(o_sat), 64'({e3[DW], e2[DW], e1[DW], e0[DW]}));
  endtask

  // With o_ready high, o_valid must drop on the next edge and i_ready return.
  task automatic handshake(input string tag);
    @(posedge clk); #1;
    chk({tag, "_vld_drop"}, 64'(o_valid), 64'(0));
    chk({tag, "_rdy_back"}, 64'(i_ready), 64'(1));
  endtask

  task automatic run_vec(input string tag, input logic [DW:0] a, b, c, d, m);
    accept_vec(a, b, c, d, m);
    collect(tag, a, b, c, d, m);
    handshake(tag);
  endtask

  function automatic logic [DW:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return (DW+1)'($urandom_range(0, 'h1FF));
      2:       return (DW+1)'($urandom_range(0, 'h0FFF));
      default: return (DW+1)'($urandom_range(0, 'h1FFFF));
    endcase
  endfunction

  initial begin
    logic [DW-1:0] hold_a;
    logic [3:0]    hold_s;
    logic [DW:0]   ra, rb, rc, rd, rm;

    repeat (3) @(negedge clk);
    chk("rst_o_valid", 64'(o_valid), 64'(0));
    chk("rst_out_A", 64'(out_A), 64'(0));
    chk("rst_out_D", 64'(out_D), 64'(0));
    chk("rst_o_sat", 64'(o_sat), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("rst_i_ready", 64'(i_ready), 64'(1));

    run_vec("t1_unit", 17'h00100, 17'h00100, 17'h00100, 17'h00100, 17'h00300);
    run_vec("t2_frac", 17'h00080, 17'h000B5, 17'h00040, 17'h00001, 17'h00A00);
    run_vec("t3_round", 17'h00001, 17'h00003, 17'h00101, 17'h00000, 17'h00080);
    run_vec("t4_sat", 17'h00100, 17'h00080, 17'h10000, 17'h000FF, 17'h00200);
    run_vec("mag0", 17'h1FFFF, 17'h00100, 17'h10000, 17'h00ABC, 17'h00000);
    run_vec("max", 17'h1FFFF, 17'h0FFFF, 17'h00100, 17'h000FF, 17'h1FFFF);

    // Downstream stall in DONE with a new vector waiting.
    o_ready = 1'b0;
    accept_vec(17'h00123, 17'h00456, 17'h00789, 17'h00ABC, 17'h00155);
    collect("t5_stall", 17'h00123, 17'h00456, 17'h00789, 17'h00ABC, 17'h00155);
    hold_a = out_A; hold_s = o_sat;
    q_A = 17'h1FFFF; mag = 17'h1FFFF; i_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("t5_vld_hold", 64'(o_valid), 64'(1));
      chk("t5_rdy_low", 64'(i_ready), 64'(0));
      chk("t5_out_stable", 64'({out_A, o_sat}), 64'({hold_a, hold_s}));
    end
    o_ready = 1'b1; i_valid = 1'b0;
    handshake("t5");

    // Reset in the middle of a multiply.
    accept_vec(17'h00200, 17'h00300, 17'h00400, 17'h00500, 17'h00700);
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    chk("t6_vld", 64'(o_valid), 64'(0));
    chk("t6_outs", 64'({out_A, out_B, out_C, out_D}), 64'(0));
    chk("t6_sat", 64'(o_sat), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rdy", 64'(i_ready), 64'(1));
    run_vec("t6_next", 17'h00180, 17'h00050, 17'h00100, 17'h00002, 17'h00A00);

    for (int n = 0; n < 8; n++) begin
      ra = rnd_op(); rb = rnd_op(); rc = rnd_op(); rd = rnd_op(); rm = rnd_op();
      run_vec($sformatf("rand%0d", n), ra, rb, rc, rd, rm);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
